// File: rtl/fetch_queue.sv
// Dual-issue instruction fetch queue: accepts one or two instructions per cycle and
// presents the two oldest entries to decode as an in-order pair with per-slot valids.
module fetch_queue #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned XLEN  = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic                     in_two,
   input  logic [XLEN-1:0]          in_pc,
   input  logic [31:0]              in_instr0,
   input  logic [31:0]              in_instr1,
   output logic                     in_ready,
   output logic [31:0]              instrA,
   output logic [31:0]              instrB,
   output logic [XLEN-1:0]          pcA,
   output logic [XLEN-1:0]          pcB,
   output logic                     validA,
   output logic                     validB,
   input  logic [1:0]               deq,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [31:0] Nop  = 32'h00000013;

   logic [31:0]     instrMem [DEPTH];
   logic [XLEN-1:0] pcMem    [DEPTH];

   logic [PtrW-1:0] rdPtrQ, rdPtrD;
   logic [PtrW-1:0] wrPtrQ, wrPtrD;
   logic [CntW-1:0] countQ, countD;

   logic [PtrW-1:0] rdPtr1;
   logic [PtrW-1:0] wrPtr1;
   logic            pushEn;
   logic [CntW-1:0] pushNum;
   logic [1:0]      avail;
   logic [1:0]      deqEff;

   assign rdPtr1 = rdPtrQ + PtrW'(1);
   assign wrPtr1 = wrPtrQ + PtrW'(1);

   // Readiness uses the pre-dequeue occupancy: no credit for a same-cycle deq.
   assign in_ready = rst_n && (countQ <= CntW'(DEPTH - 2));
   assign pushEn   = in_valid && in_ready && !flush;

   assign validA = (countQ != '0);
   assign validB = (countQ >= CntW'(2));
   assign count  = countQ;

   // Invalid slots show a NOP so decode always sees a legal encoding.
   always_comb begin
      instrA = Nop;
      pcA    = '0;
      instrB = Nop;
      pcB    = '0;
      if (validA) begin
         instrA = instrMem[rdPtrQ];
         pcA    = pcMem[rdPtrQ];
      end
      if (validB) begin
         instrB = instrMem[rdPtr1];
         pcB    = pcMem[rdPtr1];
      end
   end

   always_comb begin
      avail   = {1'b0, validA} + {1'b0, validB};
      deqEff  = (deq > avail) ? avail : deq;
      pushNum = '0;
      if (pushEn) begin
         pushNum = in_two ? CntW'(2) : CntW'(1);
      end
      rdPtrD = rdPtrQ + PtrW'(deqEff);
      wrPtrD = wrPtrQ + PtrW'(pushNum);
      countD = countQ + pushNum - CntW'(deqEff);
      if (flush) begin
         rdPtrD = '0;
         wrPtrD = '0;
         countD = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdPtrQ <= '0;
         wrPtrQ <= '0;
         countQ <= '0;
      end else begin
         rdPtrQ <= rdPtrD;
         wrPtrQ <= wrPtrD;
         countQ <= countD;
      end
   end

   // Entry storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (pushEn) begin
         instrMem[wrPtrQ] <= in_instr0;
         pcMem[wrPtrQ]    <= in_pc;
         if (in_two) begin
            instrMem[wrPtr1] <= in_instr1;
            pcMem[wrPtr1]    <= in_pc + XLEN'(4);
         end
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of the fetch queue.
module tb_fetch_queue;

   localparam int DEPTH = 8;
   localparam int XLEN  = 64;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              flush;
   logic              in_valid;
   logic              in_two;
   logic [XLEN-1:0]   in_pc;
   logic [31:0]       in_instr0;
   logic [31:0]       in_instr1;
   logic              in_ready;
   logic [31:0]       instrA;
   logic [31:0]       instrB;
   logic [XLEN-1:0]   pcA;
   logic [XLEN-1:0]   pcB;
   logic              validA;
   logic              validB;
   logic [1:0]        deq;
   logic [3:0]        count;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
   } ent_t;

   ent_t mq[$];
   int   compared   = 0;
   int   mismatched = 0;
   logic [XLEN-1:0] nextPc = 64'h1000;

   fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_two    (in_two),
      .in_pc     (in_pc),
      .in_instr0 (in_instr0),
      .in_instr1 (in_instr1),
      .in_ready  (in_ready),
      .instrA    (instrA),
      .instrB    (instrB),
      .pcA       (pcA),
      .pcB       (pcB),
      .validA    (validA),
      .validB    (validB),
      .deq       (deq),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string where);
      int n = mq.size();
      chk({where, ":validA"}, 64'(validA), 64'(n >= 1));
      chk({where, ":validB"}, 64'(validB), 64'(n >= 2));
      chk({where, ":instrA"}, 64'(instrA), 64'((n >= 1) ? mq[0].instr : 32'h13));
      chk({where, ":pcA"},    pcA,         (n >= 1) ? mq[0].pc : 64'h0);
      chk({where, ":instrB"}, 64'(instrB), 64'((n >= 2) ? mq[1].instr : 32'h13));
      chk({where, ":pcB"},    pcB,         (n >= 2) ? mq[1].pc : 64'h0);
      chk({where, ":count"},  64'(count),  64'(n));
      chk({where, ":in_ready"}, 64'(in_ready), 64'(rst_n && ((DEPTH - n) >= 2)));
   endtask

   // Reference model: applies one clock edge using the inputs currently driven.
   task automatic modelEdge();
      int  n;
      int  avail;
      int  de;
      bit  rdy;
      ent_t e;
      if (!rst_n || flush) begin
         mq.delete();
      end else begin
         n     = mq.size();
         avail = (n > 2) ? 2 : n;
         de    = (int'(deq) > avail) ? avail : int'(deq);
         rdy   = (DEPTH - n) >= 2;
         repeat (de) void'(mq.pop_front());
         if (in_valid && rdy) begin
            e = {in_instr0, in_pc};
            mq.push_back(e);
            if (in_two) begin
               e = {in_instr1, in_pc + 64'd4};
               mq.push_back(e);
            end
         end
      end
   endtask

   task automatic step(input bit f, input bit v, input bit t, input logic [31:0] i0,
                       input logic [31:0] i1, input logic [63:0] pc, input logic [1:0] d,
                       input string where);
      flush     = f;
      in_valid  = v;
      in_two    = t;
      in_instr0 = i0;
      in_instr1 = i1;
      in_pc     = pc;
      deq       = d;
      @(posedge clk);
      modelEdge();
      #1;
      checkAll(where);
   endtask

   task automatic idle(input logic [1:0] d, input string where);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 64'h0, d, where);
   endtask

   task automatic pushPair(input logic [1:0] d, input string where);
      step(1'b0, 1'b1, 1'b1, $urandom, $urandom, nextPc, d, where);
      nextPc = nextPc + 64'd8;
   endtask

   task automatic pushOne(input logic [1:0] d, input string where);
      step(1'b0, 1'b1, 1'b0, $urandom, $urandom, nextPc, d, where);
      nextPc = nextPc + 64'd4;
   endtask

   task automatic doFlush();
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0, "flush");
   endtask

   initial begin
      rst_n = 1'b0;
      #1;
      idle(2'd0, "reset0");
      idle(2'd0, "reset1");
      rst_n = 1'b1;
      #1;
      chk("reset_ready", 64'(in_ready), 64'd1);

      step(1'b0, 1'b1, 1'b1, 32'h00510093, 32'hFFB1C093, 64'h100, 2'd0, "pair");
      chk("pair_instrA", 64'(instrA), 64'h00510093);
      chk("pair_pcA", pcA, 64'h100);
      chk("pair_instrB", 64'(instrB), 64'hFFB1C093);
      chk("pair_pcB", pcB, 64'h104);
      chk("pair_count", 64'(count), 64'd2);

      doFlush();
      step(1'b0, 1'b1, 1'b0, 32'h00412083, 32'h0, 64'h200, 2'd0, "single");
      chk("single_validB", 64'(validB), 64'd0);
      chk("single_instrB", 64'(instrB), 64'h13);
      chk("single_pcB", pcB, 64'h0);

      doFlush();
      for (int i = 0; i < 4; i++) pushPair(2'd0, "fill");
      chk("fill_count", 64'(count), 64'd8);
      chk("fill_ready", 64'(in_ready), 64'd0);
      pushPair(2'd0, "full_push");
      chk("full_push_count", 64'(count), 64'd8);
      idle(2'd1, "deq7");
      chk("deq7_count", 64'(count), 64'd7);
      chk("deq7_ready", 64'(in_ready), 64'd0);
      idle(2'd1, "deq6");
      chk("deq6_count", 64'(count), 64'd6);
      chk("deq6_ready", 64'(in_ready), 64'd1);

      // Leave wr_ptr at 7 before the final pair so it straddles index 7 -> 0.
      doFlush();
      pushOne(2'd0, "wrap_lead");
      for (int i = 0; i < 7; i++) pushPair(2'd2, "wrap");
      pushPair(2'd2, "wrap_edge");
      for (int i = 0; i < 3; i++) idle(2'd2, "wrap_drain");

      doFlush();
      pushPair(2'd0, "setup5");
      pushPair(2'd0, "setup5");
      pushOne(2'd0, "setup5");
      chk("setup5_count", 64'(count), 64'd5);
      step(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 64'h300, 2'd2, "flush_push");
      chk("flush_push_count", 64'(count), 64'd0);
      chk("flush_push_validA", 64'(validA), 64'd0);
      idle(2'd0, "after_flush");
      chk("after_flush_validA", 64'(validA), 64'd0);

      pushOne(2'd0, "under_setup");
      idle(2'd2, "underflow");
      chk("underflow_count", 64'(count), 64'd0);
      idle(2'd3, "deq3_empty");

      for (int i = 0; i < 3; i++) pushPair(2'd0, "pre_reset");
      chk("pre_reset_count", 64'(count), 64'd6);
      rst_n = 1'b0;
      idle(2'd0, "mid_reset");
      chk("mid_reset_count", 64'(count), 64'd0);
      chk("mid_reset_validA", 64'(validA), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("mid_reset_ready", 64'(in_ready), 64'd1);

      for (int i = 0; i < 400; i++) begin
         logic [31:0] r;
         r = $urandom;
         rst_n = (r[5:0] != 6'd0);
         step(r[10:6] == 5'd0, r[13:11] < 3'd6, r[14], $urandom, $urandom, nextPc,
              2'($urandom_range(0, 3)), "rand");
         nextPc = nextPc + 64'd8;
      end
      rst_n = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
